// File: rtl/smem_batch_ctrl.sv
// Batch sequencer for the SMEM pipeline: steps a batch through load -> run -> output,
// throttles the pipeline with a global stall and tracks outstanding DRAM lookups.
module smem_batch_ctrl #(
    parameter int BATCH_W         = 9,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_W           = 6,
    parameter int STALL_MARGIN    = 4
) (
    input  logic               Clk_32UI,
    input  logic               reset,
    input  logic               start,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic               load_valid,
    input  logic               load_done,
    input  logic               DRAM_valid,
    input  logic               DRAM_get,
    input  logic               ret_valid,
    input  logic               output_permit,
    input  logic               output_finish,
    output logic               stall,
    output logic               output_request,
    output logic [BATCH_W-1:0] load_cnt,
    output logic [CNT_W-1:0]   outstanding,
    output logic [2:0]         state,
    output logic               batch_done,
    output logic               err_overflow,
    output logic               err_underflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        OUT_REQ = 3'd3,
        OUTPUT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(MAX_OUTSTANDING - STALL_MARGIN);

    state_t             fsm;
    state_t             fsm_next;
    logic [BATCH_W-1:0] batch_q;
    logic [BATCH_W-1:0] ret_cnt;
    logic [CNT_W-1:0]   outstanding_next;
    logic               accept;
    logic               overflow_hit;
    logic               underflow_hit;

    assign state = fsm;

    // Stall and request are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        accept           = (fsm == IDLE) && start;
        overflow_hit     = DRAM_valid && !DRAM_get && (outstanding == CNT_MAX);
        underflow_hit    = DRAM_get && !DRAM_valid && (outstanding == '0);
        fsm_next         = fsm;
        outstanding_next = outstanding;

        case (fsm)
            IDLE:    if (start) fsm_next = (batch_size == '0) ? DONE : LOAD;
            LOAD:    if (load_done) fsm_next = RUN;
            RUN:     if ((ret_cnt == batch_q) && (outstanding == '0)) fsm_next = OUT_REQ;
            OUT_REQ: if (output_permit) fsm_next = OUTPUT;
            OUTPUT:  if (output_finish) fsm_next = DONE;
            DONE:    fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase

        if (accept) begin
            outstanding_next = '0;
        end else if (DRAM_valid && !DRAM_get && !overflow_hit) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (DRAM_get && !DRAM_valid && !underflow_hit) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_32UI or posedge reset) begin
        if (reset) begin
            fsm            <= IDLE;
            stall          <= 1'b1;
            output_request <= 1'b0;
            batch_done     <= 1'b0;
            batch_q        <= '0;
            load_cnt       <= '0;
            ret_cnt        <= '0;
            outstanding    <= '0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            fsm            <= fsm_next;
            outstanding    <= outstanding_next;
            stall          <= (fsm_next != RUN) || (outstanding_next >= CNT_THR);
            output_request <= (fsm_next == OUT_REQ);
            batch_done     <= (fsm_next == DONE);

            if (accept) begin
                batch_q       <= batch_size;
                load_cnt      <= '0;
                ret_cnt       <= '0;
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end else begin
                if (overflow_hit) err_overflow <= 1'b1;
                if (underflow_hit) err_underflow <= 1'b1;
                if ((fsm == LOAD) && load_valid && (load_cnt != batch_q)) begin
                    load_cnt <= load_cnt + BATCH_W'(1);
                end
                if ((fsm == RUN) && ret_valid && (ret_cnt != batch_q)) begin
                    ret_cnt <= ret_cnt + BATCH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_smem_batch_ctrl.sv
// Bench for smem_batch_ctrl: a behavioural batch model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_smem_batch_ctrl;

    localparam int BATCH_W = 9;
    localparam int MAXO    = 8;
    localparam int CNT_W   = 4;
    localparam int MARGIN  = 2;
    localparam int THR     = MAXO - MARGIN;

    logic               Clk_32UI = 1'b0;
    logic               reset    = 1'b1;
    logic               start;
    logic [BATCH_W-1:0] batch_size;
    logic               load_valid;
    logic               load_done;
    logic               DRAM_valid;
    logic               DRAM_get;
    logic               ret_valid;
    logic               output_permit;
    logic               output_finish;
    logic               stall;
    logic               output_request;
    logic [BATCH_W-1:0] load_cnt;
    logic [CNT_W-1:0]   outstanding;
    logic [2:0]         state;
    logic               batch_done;
    logic               err_overflow;
    logic               err_underflow;

    int compared   = 0;
    int mismatched = 0;

    // Model of the batch: phase number, counters and sticky flags as plain integers.
    int m_state, m_load, m_ret, m_batch, m_out, m_eo, m_eu;
    int m_stall, m_req, m_done;

    smem_batch_ctrl #(
        .BATCH_W(BATCH_W),
        .MAX_OUTSTANDING(MAXO),
        .CNT_W(CNT_W),
        .STALL_MARGIN(MARGIN)
    ) dut (
        .Clk_32UI(Clk_32UI),
        .reset(reset),
        .start(start),
        .batch_size(batch_size),
        .load_valid(load_valid),
        .load_done(load_done),
        .DRAM_valid(DRAM_valid),
        .DRAM_get(DRAM_get),
        .ret_valid(ret_valid),
        .output_permit(output_permit),
        .output_finish(output_finish),
        .stall(stall),
        .output_request(output_request),
        .load_cnt(load_cnt),
        .outstanding(outstanding),
        .state(state),
        .batch_done(batch_done),
        .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 Clk_32UI = ~Clk_32UI;

    // Phases: 0 idle, 1 load, 2 run, 3 output request, 4 output, 5 done.
    always @(posedge Clk_32UI or posedge reset) begin
        int ns, no, nl, nr, nb, neo, neu;
        if (reset) begin
            m_state <= 0; m_load <= 0; m_ret <= 0; m_batch <= 0; m_out <= 0;
            m_eo <= 0; m_eu <= 0; m_stall <= 1; m_req <= 0; m_done <= 0;
        end else begin
            ns = m_state; no = m_out; nl = m_load; nr = m_ret; nb = m_batch;
            neo = m_eo; neu = m_eu;
            if (DRAM_valid && !DRAM_get) begin
                if (m_out == MAXO) neo = 1; else no = m_out + 1;
            end else if (DRAM_get && !DRAM_valid) begin
                if (m_out == 0) neu = 1; else no = m_out - 1;
            end
            case (m_state)
                0: if (start) begin
                    nb = int'(batch_size); nl = 0; nr = 0; no = 0; neo = 0; neu = 0;
                    ns = (nb == 0) ? 5 : 1;
                end
                1: begin
                    if (load_valid && m_load < m_batch) nl = m_load + 1;
                    if (load_done) ns = 2;
                end
                2: begin
                    if (ret_valid && m_ret < m_batch) nr = m_ret + 1;
                    if (m_ret == m_batch && m_out == 0) ns = 3;
                end
                3: if (output_permit) ns = 4;
                4: if (output_finish) ns = 5;
                default: ns = 0;
            endcase
            m_state <= ns; m_out <= no; m_load <= nl; m_ret <= nr; m_batch <= nb;
            m_eo <= neo; m_eu <= neu;
            m_stall <= ((ns != 2) || (no >= THR)) ? 1 : 0;
            m_req   <= (ns == 3) ? 1 : 0;
            m_done  <= (ns == 5) ? 1 : 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle out of reset, all outputs must follow the model.
    always @(negedge Clk_32UI) begin
        if (!reset) begin
            check_output("cyc_state", 32'(state), m_state);
            check_output("cyc_stall", 32'(stall), m_stall);
            check_output("cyc_request", 32'(output_request), m_req);
            check_output("cyc_done", 32'(batch_done), m_done);
            check_output("cyc_load_cnt", 32'(load_cnt), m_load);
            check_output("cyc_outstanding", 32'(outstanding), m_out);
            check_output("cyc_err_overflow", 32'(err_overflow), m_eo);
            check_output("cyc_err_underflow", 32'(err_underflow), m_eu);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk_32UI);
    endtask

    task automatic apply_stimulus();
        start = 0; load_valid = 0; load_done = 0; DRAM_valid = 0; DRAM_get = 0;
        ret_valid = 0; output_permit = 0; output_finish = 0;
    endtask

    initial begin
        apply_stimulus();
        batch_size = '0;
        tick(2);
        check_output("rst_state", 32'(state), 0);
        check_output("rst_stall", 32'(stall), 1);
        check_output("rst_outstanding", 32'(outstanding), 0);
        check_output("rst_request", 32'(output_request), 0);
        check_output("rst_done", 32'(batch_done), 0);
        check_output("model_rst_stall", m_stall, 1);
        reset = 0;
        tick(1);

        // Load a 4-read batch; the fifth beat must saturate.
        batch_size = 4; start = 1; tick(1); start = 0;
        check_output("load_state", 32'(state), 1);
        check_output("load_stall", 32'(stall), 1);
        load_valid = 1; tick(5); load_valid = 0;
        check_output("load_cnt_sat", 32'(load_cnt), 4);
        load_done = 1; tick(1); load_done = 0;
        check_output("run_state", 32'(state), 2);
        check_output("run_stall", 32'(stall), 0);
        check_output("model_run_state", m_state, 2);

        // Throttle at MAX-MARGIN = 6 outstanding.
        DRAM_valid = 1; tick(5);
        check_output("out5_cnt", 32'(outstanding), 5);
        check_output("out5_stall", 32'(stall), 0);
        tick(1); DRAM_valid = 0;
        check_output("out6_cnt", 32'(outstanding), 6);
        check_output("out6_stall", 32'(stall), 1);
        check_output("model_out6_stall", m_stall, 1);
        DRAM_get = 1; tick(1); DRAM_get = 0;
        check_output("get_cnt", 32'(outstanding), 5);
        check_output("get_stall", 32'(stall), 0);
        DRAM_get = 1; tick(2); DRAM_get = 0;
        DRAM_valid = 1; DRAM_get = 1; tick(1); apply_stimulus();
        check_output("both3_cnt", 32'(outstanding), 3);
        check_output("both3_err", 32'({err_overflow, err_underflow}), 0);
        DRAM_get = 1; tick(3); DRAM_get = 0;
        DRAM_valid = 1; DRAM_get = 1; tick(1); apply_stimulus();
        check_output("both0_cnt", 32'(outstanding), 0);
        check_output("both0_err", 32'({err_overflow, err_underflow}), 0);

        // Retire the batch and walk the output handshake.
        ret_valid = 1; tick(4); ret_valid = 0;
        check_output("ret_still_run", 32'(state), 2);
        tick(1);
        check_output("outreq_state", 32'(state), 3);
        check_output("outreq_request", 32'(output_request), 1);
        check_output("outreq_stall", 32'(stall), 1);
        tick(1);
        check_output("outreq_wait", 32'(state), 3);
        output_permit = 1; tick(1); output_permit = 0;
        check_output("output_state", 32'(state), 4);
        check_output("output_request_drop", 32'(output_request), 0);
        output_permit = 1; tick(1); output_permit = 0;
        check_output("output_permit_ignored", 32'(state), 4);
        output_finish = 1; tick(1); output_finish = 0;
        check_output("done_state", 32'(state), 5);
        check_output("done_pulse", 32'(batch_done), 1);
        tick(1);
        check_output("idle_state", 32'(state), 0);
        check_output("done_pulse_end", 32'(batch_done), 0);

        // Saturation and sticky errors; a start during LOAD is ignored.
        batch_size = 2; start = 1; tick(1); start = 0;
        batch_size = 7; start = 1; tick(1); start = 0;
        check_output("start_ignored", 32'(state), 1);
        DRAM_valid = 1; tick(8);
        check_output("sat_cnt", 32'(outstanding), 8);
        check_output("sat_no_err", 32'(err_overflow), 0);
        tick(1); DRAM_valid = 0;
        check_output("ovf_cnt", 32'(outstanding), 8);
        check_output("ovf_err", 32'(err_overflow), 1);
        check_output("model_ovf_err", m_eo, 1);
        DRAM_get = 1; tick(8);
        check_output("drain_cnt", 32'(outstanding), 0);
        tick(1); DRAM_get = 0;
        check_output("unf_err", 32'(err_underflow), 1);
        check_output("unf_ovf_sticky", 32'(err_overflow), 1);

        // Async reset in RUN with 5 outstanding.
        load_done = 1; tick(1); load_done = 0;
        check_output("run2_state", 32'(state), 2);
        DRAM_valid = 1; tick(5); DRAM_valid = 0;
        check_output("run2_out", 32'(outstanding), 5);
        #2 reset = 1;
        #1;
        check_output("arst_state", 32'(state), 0);
        check_output("arst_stall", 32'(stall), 1);
        check_output("arst_out", 32'(outstanding), 0);
        check_output("arst_err", 32'({err_overflow, err_underflow}), 0);
        check_output("arst_load_cnt", 32'(load_cnt), 0);
        tick(1); reset = 0;
        tick(1);

        // Empty batch goes straight to DONE; a late response then flags underflow.
        batch_size = 0; start = 1; tick(1); start = 0;
        check_output("empty_state", 32'(state), 5);
        check_output("empty_done", 32'(batch_done), 1);
        DRAM_get = 1; tick(1); DRAM_get = 0;
        check_output("empty_idle", 32'(state), 0);
        check_output("late_unf", 32'(err_underflow), 1);
        check_output("late_out", 32'(outstanding), 0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
